muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; the legal range is 4..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: operation request; sampled only when busy=0.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT, 01 DIV, 10 MULTU, 11 DIVU.
REQ-006 SHALL have port a, input, WIDTH bits: multiplicand or dividend (rs).
REQ-007 SHALL have port b, input, WIDTH bits: multiplier or divisor (rt).
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; hi/lo are valid in that cycle.
REQ-010 SHALL have port hi, output, WIDTH bits: product upper half, or remainder.
REQ-011 SHALL have port lo, output, WIDTH bits: product lower half, or quotient.
REQ-012 SHALL have port div_zero, output, 1 bit: one-cycle pulse coincident with done on a zero divisor.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, ITER, FIX and DONE.
REQ-014 SHALL latch a, b and op at the edge where start=1 and busy=0 (edge 0), then enter LOAD.
REQ-015 SHALL convert signed operands to magnitude in LOAD and preload the iteration counter with WIDTH.
REQ-016 SHALL perform exactly one shift-add (MULT) or one restoring subtract-shift (DIV) step per cycle in ITER, decrementing the counter, for WIDTH cycles.
REQ-017 SHALL apply sign correction in FIX and write hi/lo at the FIX->DONE edge.
REQ-018 SHALL assert done for the single DONE cycle, which falls WIDTH+2 cycles after edge 0, then return to IDLE.
REQ-019 SHALL drive busy=1 in LOAD, ITER and FIX, and busy=0 in IDLE and DONE.
REQ-020 SHALL set {hi,lo} to the full 2*WIDTH-bit product for MULT/MULTU.
REQ-021 SHALL, for DIV/DIVU, set lo=quotient and hi=remainder, with the quotient truncated toward zero and the remainder taking the sign of the dividend.
REQ-022 SHALL, for DIV with a = most-negative value and b = -1, give lo=a (wrap) and hi=0, with no flag raised.
REQ-023 SHALL, on DIV/DIVU with b=0, go LOAD->DONE, pulse done and div_zero 2 cycles after edge 0, and leave hi/lo unchanged.
REQ-024 SHALL ignore start while busy=1, with no effect on the operation in flight.
REQ-025 SHALL accept a start raised in the DONE cycle, so back-to-back operations are possible with zero idle cycles.
REQ-026 SHALL hold hi/lo stable between operations and keep them unchanged until the next write in FIX.

Reset
REQ-027 SHALL, on reset=1 at any edge (including mid-operation), go to IDLE and clear busy, done, div_zero, hi, lo and the counter to 0.
REQ-028 SHALL give reset priority over start in the same cycle.

Configuration
REQ-029 SHALL recognise macro MULDIV_UNSIGNED_EN.
- Defined: MULTU/DIVU treat a and b as unsigned; sign conversion and correction are skipped.
- Undefined: op[1] is ignored; MULTU executes as MULT and DIVU as DIV; latency is identical.

Verification (WIDTH=32)
REQ-030 SHALL cover: MULT a=0xFFFFFFF9 (-7), b=3 -> done at edge 0+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high for 33 cycles.
REQ-031 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 SHALL cover: DIV a=5, b=0 after a prior result -> done and div_zero high at edge 0+2, hi/lo equal to the prior values.
REQ-033 SHALL cover: MULTU a=0xFFFFFFFF, b=2 -> with macro hi=0x00000001, lo=0xFFFFFFFE; without macro hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-034 SHALL cover: start MULT, assert reset at ITER cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a start in the DONE cycle -> second result at +34 with no gap.

Source files
------------

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq : sequential multiply / divide unit (MIPS-style HI/LO results).
//
// One shift-add (multiply) or restoring subtract-shift (divide) step per
// cycle. Signed operands are reduced to magnitudes in LOAD. The result sign
// is restored in FIX. HI/LO are written on the FIX->DONE edge and hold
// their value until the next completed operation.
//
// Build option:
//   MULDIV_UNSIGNED_EN  defined   : MULTU/DIVU (op[1]=1) run unsigned.
//                       undefined : op[1] is ignored and every op is signed.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   operation request, sampled only while busy=0
//   op[1:0]   in   00 MULT, 01 DIV, 10 MULTU, 11 DIVU
//   a[W-1:0]  in   multiplicand / dividend
//   b[W-1:0]  in   multiplier / divisor
//   busy      out  operation in flight (LOAD, ITER, FIX)
//   done      out  one-cycle pulse, hi/lo valid
//   hi[W-1:0] out  product upper half / remainder
//   lo[W-1:0] out  product lower half / quotient
//   div_zero  out  one-cycle pulse with done when the divisor was zero
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | operands to magnitudes, counter preload (zero divisor handled here)
// ITER  | one multiply/divide step per cycle, WIDTH cycles
// FIX   | sign correction, hi/lo written on exit
// DONE  | done pulse; a new start is accepted here
// ---------------------------------------------------------------------------
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              is_div_q;
  logic              signed_q;
  logic              neg_a_q, neg_b_q;
  logic              zhold_q;
  logic [WIDTH-1:0]  opd_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  acc_hi_q;   // partial product upper / partial remainder
  logic [WIDTH-1:0]  acc_lo_q;   // multiplier bits / quotient bits
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic              busy_q, done_q, div_zero_q;

  // signedness of a request at the accept edge
  logic              req_signed;
`ifdef MULDIV_UNSIGNED_EN
  assign req_signed = ~op[1];
`else
  logic unused_op1;
  assign unused_op1 = op[1];
  assign req_signed = 1'b1;
`endif

  // LOAD-stage magnitudes
  logic              sa, sb;
  logic [WIDTH-1:0]  mag_a, mag_b;

  always_comb begin
    sa    = signed_q & a_q[WIDTH-1];
    sb    = signed_q & b_q[WIDTH-1];
    mag_a = sa ? (~a_q + 1'b1) : a_q;
    mag_b = sb ? (~b_q + 1'b1) : b_q;
  end

  // ITER step datapath
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic              div_take;
  logic [WIDTH-1:0]  div_sub;
  logic [WIDTH-1:0]  acc_hi_d, acc_lo_d;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_take  = (div_shift >= {1'b0, opd_q});
    // true difference is below the divisor, so the low WIDTH bits suffice
    div_sub   = div_shift[WIDTH-1:0] - opd_q;
    if (is_div_q) begin
      acc_hi_d = div_take ? div_sub : div_shift[WIDTH-1:0];
      acc_lo_d = {acc_lo_q[WIDTH-2:0], div_take};
    end else begin
      acc_hi_d = mul_sum[WIDTH:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // FIX-stage sign correction
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   hi_d, lo_d;

  always_comb begin
    prod_raw = {acc_hi_q, acc_lo_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? (~prod_raw + 1'b1) : prod_raw;
    quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_lo_q + 1'b1) : acc_lo_q;
    rem_fix  = neg_a_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
    if (is_div_q) begin
      hi_d = rem_fix;
      lo_d = quo_fix;
    end else begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      signed_q   <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      zhold_q    <= 1'b0;
      opd_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            is_div_q <= op[0];
            signed_q <= req_signed;
            zhold_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end else begin
            state_q  <= IDLE;
          end
        end
        LOAD: begin
          if (is_div_q && (b_q == '0)) begin
            // zero divisor: one extra LOAD cycle gives a fixed two-cycle
            // turnaround; hi/lo are left untouched
            if (zhold_q) begin
              zhold_q    <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              zhold_q    <= 1'b1;
            end
          end else begin
            neg_a_q  <= sa;
            neg_b_q  <= sb;
            acc_hi_q <= '0;
            if (is_div_q) begin
              opd_q    <= mag_b;
              acc_lo_q <= mag_a;
            end else begin
              opd_q    <= mag_a;
              acc_lo_q <= mag_b;
            end
            cnt_q   <= CW'(WIDTH);
            state_q <= ITER;
          end
        end
        ITER: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op from the current (post-edge) slot. Returns the number of
  // edges from the accept edge to the first cycle with done high.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic poke, output int lat, output logic dz, output logic busy_ok);
    lat     = -1;
    dz      = 1'b0;
    busy_ok = 1'b1;
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!busy || done) busy_ok = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (poke && k == 5) begin
        start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1;
      end
      if (poke && k == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        dz  = div_zero;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  int   lat;
  logic dz, bok;
  logic saw_done;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz",   {63'd0, div_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // MULT -7 * 3 = -21
    do_op(2'b00, 32'hFFFFFFF9, 32'd3, 1'b0, lat, dz, bok);
    chk("mult_lat",  lat, 34);
    chk("mult_busy", {63'd0, bok}, 64'd1);
    chk("mult_dz",   {63'd0, dz}, 64'd0);
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    @(posedge clk); #1;
    chk("done_pulse", {62'd0, done, busy}, 64'd0);

    // DIV -7 / 2 = -3 rem -1
    do_op(2'b01, 32'hFFFFFFF9, 32'd2, 1'b0, lat, dz, bok);
    chk("div_lat",  lat, 34);
    chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    // DIV most-negative / -1 wraps
    do_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, dz, bok);
    chk("ovf_dz",   {63'd0, dz}, 64'd0);
    chk("ovf_hilo", {hi, lo}, 64'h00000000_80000000);

    // DIVU 100 / 7 = 14 rem 2 (same with or without unsigned build)
    do_op(2'b11, 32'd100, 32'd7, 1'b0, lat, dz, bok);
    chk("divu_hilo", {hi, lo}, 64'h00000002_0000000E);

    // DIV by zero keeps prior hi/lo
    do_op(2'b01, 32'd5, 32'd0, 1'b0, lat, dz, bok);
    chk("dz_lat",  lat, 2);
    chk("dz_flag", {63'd0, dz}, 64'd1);
    chk("dz_busy", {63'd0, bok}, 64'd1);
    chk("dz_hilo", {hi, lo}, 64'h00000002_0000000E);
    @(posedge clk); #1;
    chk("dz_pulse", {62'd0, done, div_zero}, 64'd0);

    // DIV 7 / -2 = -3 rem 1
    do_op(2'b01, 32'd7, 32'hFFFFFFFE, 1'b0, lat, dz, bok);
    chk("divn_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);

    // MULTU 0xFFFFFFFF * 2
    do_op(2'b10, 32'hFFFFFFFF, 32'd2, 1'b0, lat, dz, bok);
    chk("multu_lat", lat, 34);
`ifdef MULDIV_UNSIGNED_EN
    chk("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);
`else
    chk("multu_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
`endif

    // start while busy is ignored
    do_op(2'b00, 32'd6, 32'd7, 1'b1, lat, dz, bok);
    chk("ign_lat",  lat, 34);
    chk("ign_hilo", {hi, lo}, 64'h00000000_0000002A);

    // reset in ITER cycle 10
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("mrst_nodone", {63'd0, saw_done}, 64'd0);

    // back-to-back: second start in the DONE cycle of the first
    do_op(2'b00, 32'd3, 32'd5, 1'b0, lat, dz, bok);
    chk("b2b1_hilo", {hi, lo}, 64'h00000000_0000000F);
    do_op(2'b00, 32'hFFFFFFFE, 32'd4, 1'b0, lat, dz, bok);
    chk("b2b2_lat",  lat, 34);
    chk("b2b2_busy", {63'd0, bok}, 64'd1);
    chk("b2b2_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
